lsu_mem_bridge: RTL and testbench
=================================

Name: lsu_mem_bridge

Overview:
- Load/store unit sitting directly upstream of the byte-lane RAM (`mem`) inside `proc`.
- Accepts one RV32 load/store request at a time from the execute stage.
- Drives the RAM's per-lane write enables, lane data, word address and read data.
- Rotates store data onto lanes, extracts and sign/zero-extends load data, and splits accesses that straddle a word boundary into two RAM accesses.

Parameters:
- ADDR_WIDTH, 16: RAM word-address width.
- DATA_WIDTH_BYTES, 4: lanes per RAM word. Fixed at 4; other values are unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- req_unsigned  in  1  zero-extend the load (LBU/LHU)
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  one-cycle completion pulse (loads and stores)
- rsp_rdata  out  32  extended load data; 0 for stores
- mem_addr  out  ADDR_WIDTH  RAM word address
- mem_wenableL  out  4  per-lane write enable, active-low
- mem_wdata  out  32  lane i = bits [8i+7:8i]
- mem_rdata  in  32  lane data, valid the cycle after mem_addr is presented

Behaviour:
- RAM timing: writes commit on the clk edge while the lane's wenableL=0. Read data for the address presented in cycle N appears on mem_rdata in cycle N+1.
- States: IDLE, ACC0, ACC1, RESP. Reset → IDLE.
- Reset values: req_ready=0 while rst is high, rsp_valid=0, rsp_rdata=0, mem_addr=0, mem_wenableL=4'b1111, mem_wdata=0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/size/unsigned/addr/wdata.
  - Compute off=addr[1:0] and nbytes=1/2/4.
  - split = (off+nbytes > 4).
  - Go to ACC0.
- ACC0:
  - mem_addr = addr[ADDR_WIDTH+1:2].
  - Lanes off .. min(off+nbytes,4)-1 are active.
  - Store: wenableL=0 on active lanes; mem_wdata lane off+k = wdata byte k.
  - Load: wenableL=4'b1111.
  - Next state: split ? ACC1 : RESP.
- ACC1:
  - Capture mem_rdata (first word) into the holding register.
  - mem_addr = word0+1, wrapping modulo 2^ADDR_WIDTH.
  - Active lanes 0 .. off+nbytes-5 carry the remaining bytes; for stores, lane j = wdata byte (4-off+j).
  - Next state: RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - Loads: assemble bytes from the held first word and the current mem_rdata (split), or from mem_rdata alone (non-split).
  - Extension: sign-extend from bit 7/15 unless req_unsigned; word loads are not extended.
  - Next state: IDLE.
- req_ready=0 in ACC0/ACC1/RESP; req_valid there is ignored and does not stall.
- Latency, request accepted at edge T:
  - Non-split: rsp_valid in cycle T+2.
  - Split: rsp_valid in cycle T+3.
  - Throughput is one request per 3 (or 4) cycles.
- The response has no back-pressure; the consumer must take rsp_valid when asserted.
- mem_wenableL=4'b1111 in IDLE and RESP, and in any cycle with rst=1.
- Reset mid-operation:
  - Return to IDLE and drop the pending request.
  - No rsp_valid is produced for it.
  - A store lane already committed before the reset edge stays written; no further lanes are written.
- Byte accesses never split. Half accesses split only at off=3. Word accesses split at off=1, 2, 3.

Test Plan:
- Aligned word store addr 0x010, data 0xDEADBEEF, then word load 0x010 → ACC0 wenableL=4'b0000, mem_addr=4; load rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after accept.
- Byte load at 0x013 of word 0x80FF7F01: signed → 0xFFFFFF80; unsigned → 0x00000080. Half load at 0x012: signed → 0xFFFF80FF.
- Split word store 0x0F (data 0x11223344) at byte 0x00F: ACC0 mem_addr=3, wenableL=4'b0111, lane3=0x44. ACC1 mem_addr=4, wenableL=4'b1000, lanes0..2=0x33,0x22,0x11. Reload → 0x11223344, rsp_valid 3 cycles after accept.
- Split half load at 0x007 with byte 0x007=0xAB, byte 0x008=0xCD → rsp_rdata=0xFFFFCDAB. Top-address wrap: word access at the last byte address reads its second word from mem_addr=0.
- req_valid held high continuously → exactly one accept per IDLE visit; req_ready low in ACC0/ACC1/RESP; no request lost or duplicated.
- rst asserted during ACC1 of a split store → wenableL=4'b1111 that cycle, state IDLE next cycle, no rsp_valid, second word unchanged.

Source files
------------

// File: rtl/lsu_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_bridge_if
// Brief   : Request/response and byte-lane RAM signals of the LSU bridge.
// Revision: 1.0 - initial release
// ============================================================================
interface lsu_mem_bridge_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_wenableL;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    // The bridge itself.
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wenableL, mem_wdata
    );

    // Execute stage plus RAM, seen from the outside.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wenableL, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_bridge
// Brief   : RV32 load/store unit in front of a 4-lane byte RAM; rotates lanes,
//           extends loads and splits word-straddling accesses in two.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_mem_bridge #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH_BYTES = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    lsu_mem_bridge_if.slave bus
);
    localparam int LANES = DATA_WIDTH_BYTES;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q;
    logic                  uns_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           hold_q;

    logic [LANES-1:0]      w_lane_base;
    logic [2*LANES-1:0]    w_lane_mask;
    logic                  w_split;
    logic [5:0]            w_sh;
    logic [ADDR_WIDTH-1:0] w_word0;
    logic [ADDR_WIDTH-1:0] w_word1;
    logic [31:0]           w_wrot;
    logic [63:0]           w_ld_pair;
    logic [31:0]           w_ld_raw;
    logic [31:0]           w_ld_ext;

    // Active lanes across both words: low half is the first word, high half the second.
    always_comb begin
        w_lane_base = '1;
        case (size_q)
            2'd0:    w_lane_base = LANES'(1);
            2'd1:    w_lane_base = LANES'(3);
            default: w_lane_base = '1;
        endcase
    end

    assign w_lane_mask = {{LANES{1'b0}}, w_lane_base} << addr_q[1:0];
    assign w_split     = |w_lane_mask[2*LANES-1:LANES];
    assign w_sh        = {1'b0, addr_q[1:0], 3'b000};
    assign w_word0     = addr_q[ADDR_WIDTH+1:2];
    assign w_word1     = w_word0 + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // A left rotate by off bytes serves both halves of a split store.
    assign w_wrot      = 32'({wdata_q, wdata_q} >> (6'd32 - w_sh));
    assign w_ld_pair   = w_split ? {bus.mem_rdata, hold_q} : {bus.mem_rdata, bus.mem_rdata};
    assign w_ld_raw    = 32'(w_ld_pair >> w_sh);

    always_comb begin
        w_ld_ext = w_ld_raw;
        case (size_q)
            2'd0:    w_ld_ext = uns_q ? {24'd0, w_ld_raw[7:0]}
                                      : {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
            2'd1:    w_ld_ext = uns_q ? {16'd0, w_ld_raw[15:0]}
                                      : {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
            default: w_ld_ext = w_ld_raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            hold_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.req_valid) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state_q == S_ACC1) begin
                hold_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.req_ready    = 1'b0;
        bus.rsp_valid    = 1'b0;
        bus.rsp_rdata    = 32'd0;
        bus.mem_addr     = '0;
        bus.mem_wenableL = 4'b1111;
        bus.mem_wdata    = 32'd0;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = S_ACC0;
                end
            end
            S_ACC0: begin
                bus.mem_addr  = w_word0;
                bus.mem_wdata = w_wrot;
                if (we_q) begin
                    bus.mem_wenableL = ~w_lane_mask[LANES-1:0];
                end
                state_d = w_split ? S_ACC1 : S_RESP;
            end
            S_ACC1: begin
                bus.mem_addr  = w_word1;
                bus.mem_wdata = w_wrot;
                if (we_q) begin
                    bus.mem_wenableL = ~w_lane_mask[2*LANES-1:LANES];
                end
                state_d = S_RESP;
            end
            default: begin
                bus.rsp_valid = 1'b1;
                if (!we_q) begin
                    bus.rsp_rdata = w_ld_ext;
                end
                state_d = S_IDLE;
            end
        endcase
        // Reset is synchronous, so the state may still be mid-access in a reset cycle.
        if (rst) begin
            bus.req_ready    = 1'b0;
            bus.rsp_valid    = 1'b0;
            bus.rsp_rdata    = 32'd0;
            bus.mem_addr     = '0;
            bus.mem_wenableL = 4'b1111;
            bus.mem_wdata    = 32'd0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_mem_bridge
// Brief   : Directed and random load/store traffic against a byte-array model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_mem_bridge;
    localparam int AW = 6;
    localparam int NB = 4 << AW;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    lsu_mem_bridge_if #(.ADDR_WIDTH(AW)) bus ();

    lsu_mem_bridge #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH_BYTES(4)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-lane RAM environment: one-cycle read latency, per-lane active-low writes.
    logic [7:0] ram [NB];
    logic       ram_init;

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < NB; i++) ram[i] <= init_byte(i);
        end else begin
            for (int l = 0; l < 4; l++)
                if (!bus.mem_wenableL[l]) ram[{bus.mem_addr, 2'(l)}] <= bus.mem_wdata[8*l +: 8];
        end
        bus.mem_rdata <= {ram[{bus.mem_addr, 2'd3}], ram[{bus.mem_addr, 2'd2}],
                          ram[{bus.mem_addr, 2'd1}], ram[{bus.mem_addr, 2'd0}]};
    end

    // Reference model: flat byte memory.
    logic [7:0] ref_mem [NB];

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [1:0] s, input logic u);
        logic [31:0] v;
        int          n;
        v = '0;
        n = nbytes(s);
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[8'(a + k)];
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic ref_store(input logic [7:0] a, input logic [1:0] s, input logic [31:0] d);
        for (int k = 0; k < nbytes(s); k++) ref_mem[8'(a + k)] = d[8*k +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    logic [AW-1:0] obs_addr [1:2];
    logic [3:0]    obs_wen  [1:2];
    logic [31:0]   obs_wd   [1:2];

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [7:0] addr, input logic [31:0] wdata, input logic hold,
                           output logic [31:0] rdata, output int lat);
        @(negedge clk);
        check("ready_idle", 32'(bus.req_ready), 32'd1);
        check("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            if (lat <= 2) begin
                obs_addr[lat] = bus.mem_addr;
                obs_wen[lat]  = bus.mem_wenableL;
                obs_wd[lat]   = bus.mem_wdata;
            end
            check("ready_busy", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        if (!bus.rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
        check("ready_resp", 32'(bus.req_ready), 32'd0);
        rdata = bus.rsp_rdata;
    endtask

    task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] wdata, input logic hold,
                         output logic [31:0] got);
        int          lat;
        int          exp_lat;
        logic [31:0] exp;
        exp_lat = (int'(addr[1:0]) + nbytes(size) > 4) ? 3 : 2;
        exp     = we ? 32'd0 : ref_load(addr, size, uns);
        run_req(we, size, uns, addr, wdata, hold, got, lat);
        check("latency", 32'(lat), 32'(exp_lat));
        check(we ? "st_rdata" : "ld_rdata", got, exp);
        if (we) ref_store(addr, size, wdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] w;
        logic [31:0] e;
        logic        hold;

        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < NB; i++) ref_mem[i] = init_byte(i);
        rst              = 1'b1;
        ram_init         = 1'b1;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wen", 32'(bus.mem_wenableL), 32'hF);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        bus.req_valid = 1'b0;
        ram_init      = 1'b0;
        rst           = 1'b0;

        // Aligned word store then load.
        do_op(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, got);
        check("w_st_addr", 32'(obs_addr[1]), 32'd4);
        check("w_st_wen", 32'(obs_wen[1]), 32'h0);
        check("w_st_wdata", obs_wd[1], 32'hDEADBEEF);
        do_op(1'b0, 2'd2, 1'b0, 8'h10, 32'd0, 1'b0, got);
        check("w_ld_const", got, 32'hDEADBEEF);

        // Sign/zero extension.
        do_op(1'b1, 2'd2, 1'b0, 8'h10, 32'h80FF7F01, 1'b0, got);
        do_op(1'b0, 2'd0, 1'b0, 8'h13, 32'd0, 1'b0, got);
        check("lb_const", got, 32'hFFFFFF80);
        do_op(1'b0, 2'd0, 1'b1, 8'h13, 32'd0, 1'b0, got);
        check("lbu_const", got, 32'h00000080);
        do_op(1'b0, 2'd1, 1'b0, 8'h12, 32'd0, 1'b0, got);
        check("lh_const", got, 32'hFFFF80FF);

        // Split word store across words 3 and 4.
        do_op(1'b1, 2'd2, 1'b0, 8'h0F, 32'h11223344, 1'b0, got);
        check("sp_addr0", 32'(obs_addr[1]), 32'd3);
        check("sp_wen0", 32'(obs_wen[1]), 32'h7);
        check("sp_lane3", 32'(obs_wd[1][31:24]), 32'h44);
        check("sp_addr1", 32'(obs_addr[2]), 32'd4);
        check("sp_wen1", 32'(obs_wen[2]), 32'h8);
        check("sp_lanes012", 32'(obs_wd[2][23:0]), 32'h112233);
        do_op(1'b0, 2'd2, 1'b0, 8'h0F, 32'd0, 1'b0, got);
        check("sp_ld_const", got, 32'h11223344);

        // Split half load.
        do_op(1'b1, 2'd0, 1'b0, 8'h07, 32'h000000AB, 1'b0, got);
        do_op(1'b1, 2'd0, 1'b0, 8'h08, 32'h000000CD, 1'b0, got);
        do_op(1'b0, 2'd1, 1'b0, 8'h07, 32'd0, 1'b0, got);
        check("lh_split_const", got, 32'hFFFFCDAB);

        // Word access at the last byte wraps to word 0.
        do_op(1'b1, 2'd2, 1'b0, 8'hFF, 32'hCAFEF00D, 1'b0, got);
        check("wrap_addr0", 32'(obs_addr[1]), 32'(NB / 4 - 1));
        check("wrap_addr1", 32'(obs_addr[2]), 32'd0);
        do_op(1'b0, 2'd2, 1'b0, 8'hFF, 32'd0, 1'b0, got);
        check("wrap_ld_const", got, 32'hCAFEF00D);
        check("wrap_addr1_ld", 32'(obs_addr[2]), 32'd0);

        // Randomized traffic, with stretches of req_valid held high.
        hold = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i % 25 == 0) hold = 1'($urandom_range(0, 1));
            w = $urandom();
            do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, NB - 1)), w, hold, got);
        end
        bus.req_valid = 1'b0;

        // Reset during the second half of a split store.
        @(negedge clk);
        check("mr_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 8'h26;
        bus.req_wdata    = 32'h55667788;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mr_wen0", 32'(bus.mem_wenableL), 32'h3);
        @(negedge clk);
        check("mr_wen1", 32'(bus.mem_wenableL), 32'hC);
        rst = 1'b1;
        #1;
        check("mr_wen_rst", 32'(bus.mem_wenableL), 32'hF);
        check("mr_rsp_rst", 32'(bus.rsp_valid), 32'd0);
        ref_store(8'h26, 2'd1, 32'h00007788);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_idle", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("mr_no_rsp", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end
        do_op(1'b0, 2'd2, 1'b0, 8'h28, 32'd0, 1'b0, got);
        do_op(1'b0, 2'd1, 1'b1, 8'h26, 32'd0, 1'b0, got);
        check("mr_first_half", got, 32'h00007788);

        // Whole-RAM comparison against the model.
        @(negedge clk);
        for (int i = 0; i < NB / 4; i++) begin
            w = '0;
            e = '0;
            for (int l = 0; l < 4; l++) begin
                w[8*l +: 8] = ram[4*i + l];
                e[8*l +: 8] = ref_mem[4*i + l];
            end
            check("ram_word", w, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
